// File: rtl/fp8_pkg.sv
// Shared E4M3 definitions for the FP8 divider.
// No ports. Provides the bias, field widths, saturation magnitude,
// the fp8_t field view, the divider FSM states and a zero test.
package fp8_pkg;

    localparam int         FP8_BIAS    = 7;
    localparam int         EXP_W       = 4;
    localparam int         MAN_W       = 3;
    localparam logic [6:0] FP8_MAX_MAG = 7'b1111_111;

    typedef struct packed {
        logic             s;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
    } fp8_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } div_state_e;

    // Exponent 0 encodes zero; the mantissa field is ignored.
    function automatic logic is_zero(fp8_t x);
        return (x.e == '0);
    endfunction

endpackage

// File: rtl/fp8_div_pack.sv
// Combinational normalize-and-pack stage of the FP8 divider.
// Ports:
//   sign     in   result sign
//   e        in   unnormalized biased exponent Ea-Eb+bias (signed)
//   q        in   5-bit quotient, value q[4].q[3:0]
//   quotient out  packed E4M3 result (saturated or flushed)
//   of       out  exponent above 15, result saturated
//   uf       out  exponent below 1, result flushed to +0
module fp8_div_pack
    import fp8_pkg::*;
(
    input  logic              sign,
    input  logic signed [5:0] e,
    input  logic        [4:0] q,
    output fp8_t              quotient,
    output logic              of,
    output logic              uf
);

    logic signed [5:0] e_n;
    logic        [2:0] m_n;

    always_comb begin
        // Quotient lies in (0.5, 2): when the integer bit is clear, shift
        // left by one and take the next three bits; extra bits truncate.
        e_n = e;
        m_n = q[3:1];
        if (!q[4]) begin
            e_n = e - 6'sd1;
            m_n = q[2:0];
        end

        of       = 1'b0;
        uf       = 1'b0;
        quotient = '{s: sign, e: e_n[3:0], m: m_n};
        if (e_n > 6'sd15) begin
            of       = 1'b1;
            quotient = {sign, FP8_MAX_MAG};
        end else if (e_n < 6'sd1) begin
            uf       = 1'b1;
            quotient = '0;
        end
    end

endmodule

// File: rtl/fp8_divider_seq.sv
// Sequential E4M3 divider, quotient = a / b, restoring division with one
// quotient bit per cycle over five cycles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   a, b                  dividend, divisor (E4M3)
//   out_valid / out_ready result handshake (valid only in DONE)
//   quotient              registered E4M3 result
//   flags                 {dz, of, uf}
module fp8_divider_seq
    import fp8_pkg::*;
#(
    parameter int BIAS = FP8_BIAS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic [2:0] flags
);

    div_state_e state_q, state_d;
    logic       sign_q, sign_d;
    logic [3:0] ea_q, ea_d, eb_q, eb_d;
    logic [3:0] mb_q, mb_d;
    logic [4:0] r_q, r_d;
    logic [4:0] quo_q, quo_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quotient_q, quotient_d;
    logic [2:0] flags_q, flags_d;

    fp8_t a_f, b_f;
    assign a_f = a;
    assign b_f = b;

    logic              q_bit;
    logic        [4:0] r_sub;
    logic        [4:0] q_next;
    logic signed [5:0] e_raw;
    fp8_t              pk_q;
    logic              pk_of, pk_uf;

    // One restoring step; r stays below 2*mb so 5 bits always suffice.
    always_comb begin
        q_bit  = (r_q >= {1'b0, mb_q});
        r_sub  = q_bit ? (r_q - {1'b0, mb_q}) : r_q;
        q_next = {quo_q[3:0], q_bit};
        e_raw  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed(6'(BIAS));
    end

    // Packs the quotient including the bit produced this cycle, so the
    // result is captured on the same edge as the final iteration.
    fp8_div_pack u_pack (
        .sign     (sign_q),
        .e        (e_raw),
        .q        (q_next),
        .quotient (pk_q),
        .of       (pk_of),
        .uf       (pk_uf)
    );

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        ea_d       = ea_q;
        eb_d       = eb_q;
        mb_d       = mb_q;
        r_d        = r_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
        flags_d    = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = a_f.s ^ b_f.s;
                    ea_d   = a_f.e;
                    eb_d   = b_f.e;
                    mb_d   = {1'b1, b_f.m};
                    r_d    = {2'b01, a_f.m};
                    quo_d  = '0;
                    cnt_d  = '0;
                    if (is_zero(b_f)) begin
                        quotient_d = {a_f.s ^ b_f.s, FP8_MAX_MAG};
                        flags_d    = 3'b100;
                        state_d    = DONE;
                    end else if (is_zero(a_f)) begin
                        quotient_d = '0;
                        flags_d    = 3'b000;
                        state_d    = DONE;
                    end else begin
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                r_d   = {r_sub[3:0], 1'b0};
                quo_d = q_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    quotient_d = pk_q;
                    flags_d    = {1'b0, pk_of, pk_uf};
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            ea_q       <= '0;
            eb_q       <= '0;
            mb_q       <= '0;
            r_q        <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            quotient_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            ea_q       <= ea_d;
            eb_q       <= eb_d;
            mb_q       <= mb_d;
            r_q        <= r_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            quotient_q <= quotient_d;
            flags_q    <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quotient_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp8_divider_seq.sv
// Self-checking bench for fp8_divider_seq: directed cases, reset abort,
// then randomized operands against an arithmetic reference model.
module tb_fp8_divider_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] quotient;
    logic [2:0] flags;

    int n_chk = 0;
    int n_err = 0;

    fp8_divider_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Value of a normal code is (8+M)/8 * 2^(E-7); the truncated quotient
    // mantissa is floor(8*num/den)-8 when num>=den, else one octave lower.
    function automatic logic [10:0] model(input logic [7:0] aa, input logic [7:0] bb);
        int   ea, eb, num, den, e, m;
        logic s;
        s  = aa[7] ^ bb[7];
        ea = int'(aa[6:3]);
        eb = int'(bb[6:3]);
        if (eb == 0) return {3'b100, s, 7'h7f};
        if (ea == 0) return 11'h000;
        num = 8 + int'(aa[2:0]);
        den = 8 + int'(bb[2:0]);
        e   = ea - eb + 7;
        if (num >= den) begin
            m = (8 * num) / den - 8;
        end else begin
            e = e - 1;
            m = (16 * num) / den - 8;
        end
        if (e > 15) return {3'b010, s, 7'h7f};
        if (e < 1)  return {3'b001, 8'h00};
        return {3'b000, s, 4'(e), 3'(m)};
    endfunction

    // Called just after a falling edge with the DUT idle.
    task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input int hold);
        logic [10:0] ref_v;
        logic [7:0]  held;
        int          k;
        int          want_lat;
        ref_v    = model(aa, bb);
        want_lat = (aa[6:3] == 4'd0 || bb[6:3] == 4'd0) ? 0 : 5;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = aa;
        b         = bb;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(want_lat));
        chk("quotient", 32'(quotient), 32'(ref_v[7:0]));
        chk("flags", 32'(flags), 32'(ref_v[10:8]));
        held = quotient;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_quotient", 32'(quotient), 32'(held));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        // Handshake with in_valid also high: must not be taken in DONE.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'($urandom);
        b         = 8'($urandom);
        @(negedge clk);
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    function automatic logic [7:0] rand_op();
        logic [7:0] v;
        v = 8'($urandom);
        if ($urandom_range(0, 7) == 0) v[6:3] = 4'd0;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'b0_1001_110, 8'b0_1000_110, 0);  // 7.0 / 3.5
        run_op(8'b1_1000_000, 8'b0_1000_110, 3);  // -2.0 / 3.5, held 3 cycles
        run_op(8'b0_1001_100, 8'b0_0111_100, 1);  // 6.0 / 1.5
        run_op(8'b0_1000_110, 8'b0_0000_000, 0);  // 3.5 / 0
        run_op(8'b0_0000_000, 8'b0_1000_110, 2);  // 0 / 3.5
        run_op(8'b1_0111_000, 8'b0_0000_000, 0);  // -1.0 / 0
        run_op(8'b0_1111_000, 8'b0_0001_000, 0);  // overflow
        run_op(8'b0_0001_000, 8'b0_1111_000, 0);  // underflow

        // Reset during the third DIVIDE cycle aborts the operation.
        in_valid = 1'b1;
        a        = 8'b0_1001_110;
        b        = 8'b0_1000_110;
        @(negedge clk);
        in_valid = 1'b0;
        chk("div_busy", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(8'b1_1010_011, 8'b0_0110_101, 1);

        for (int i = 0; i < 200; i++) begin
            run_op(rand_op(), rand_op(), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
